// File: rtl/core_dbg_pkg.sv
// Shared types and constants for the core debug register page:
// run-control states, halt causes, register indices and bit positions.
package core_dbg_pkg;

    typedef enum logic [2:0] {
        ST_RUNNING  = 3'd0,
        ST_HALTING  = 3'd1,
        ST_HALTED   = 3'd2,
        ST_RESUMING = 3'd3,
        ST_STEPPING = 3'd4
    } dbg_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_HALT = 3'd1,
        CAUSE_BP0  = 3'd2,
        CAUSE_BP1  = 3'd3,
        CAUSE_STEP = 3'd4
    } dbg_cause_e;

    localparam int unsigned REG_CTRL       = 0;
    localparam int unsigned REG_STATUS     = 1;
    localparam int unsigned REG_STATUS_CLR = 2;
    localparam int unsigned REG_PC_SNAP    = 3;
    localparam int unsigned REG_BP0_ADDR   = 4;
    localparam int unsigned REG_BP0_CTRL   = 5;
    localparam int unsigned REG_BP1_ADDR   = 6;
    localparam int unsigned REG_BP1_CTRL   = 7;
    localparam int unsigned REG_CYCLES     = 8;
    localparam int unsigned REG_ID         = 9;

    localparam int unsigned CTRL_HALT_BIT   = 0;
    localparam int unsigned CTRL_RESUME_BIT = 1;
    localparam int unsigned CTRL_STEP_BIT   = 2;

    localparam int unsigned STAT_BPHIT_BIT = 8;
    localparam int unsigned STAT_TOERR_BIT = 9;

    localparam logic [31:0] DBG_ID_DEFAULT = 32'hDC0D_0001;

    function automatic logic [31:0] pack_status(input dbg_state_e st, input dbg_cause_e cause,
                                                input logic bp_hit, input logic to_err);
        logic [31:0] s;
        s                 = '0;
        s[2:0]            = st;
        s[6:4]            = cause;
        s[STAT_BPHIT_BIT] = bp_hit;
        s[STAT_TOERR_BIT] = to_err;
        return s;
    endfunction

endpackage

// File: rtl/core_dbg_page_if.sv
// Request/response bus between the APB debug slave and the debug register page.
interface core_dbg_page_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  core_dbg_req;
    logic                  core_dbg_wr_rd;
    logic [ADDR_WIDTH-1:0] core_dbg_addr;
    logic [DATA_WIDTH-1:0] core_dbg_wdata;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_rvalid;

    modport master (
        output core_dbg_req, core_dbg_wr_rd, core_dbg_addr, core_dbg_wdata,
        input  dbg_rdata, dbg_rvalid
    );

    modport slave (
        input  core_dbg_req, core_dbg_wr_rd, core_dbg_addr, core_dbg_wdata,
        output dbg_rdata, dbg_rvalid
    );
endinterface

// File: rtl/core_dbg_bp_match.sv
// Single PC breakpoint comparator; the caller decides in which states a hit matters.
module core_dbg_bp_match #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] bp_addr,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  hit
);
    assign hit = en && (bp_addr == pc);
endmodule

// File: rtl/core_dbg_page.sv
// Debug register page: run-control FSM (halt/resume/step), two PC breakpoints,
// halt PC snapshot and run-cycle counter behind a one-cycle request bus.
module core_dbg_page
    import core_dbg_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 5,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           HALT_TIMEOUT = 64,
    parameter logic [DATA_WIDTH-1:0] DBG_ID       = DATA_WIDTH'(DBG_ID_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    core_dbg_page_if.slave        dbg_bus,
    input  logic [DATA_WIDTH-1:0] core_pc,
    input  logic                  core_retire,
    input  logic                  core_halted,
    output logic                  dbg_halt_req
);

    localparam int unsigned     TO_W    = $clog2(HALT_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(HALT_TIMEOUT - 1);

    dbg_state_e            state_q, state_d;
    dbg_cause_e            cause_q, cause_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  bp_hit_q, bp_hit_d;
    logic                  to_err_q, to_err_d;
    logic [DATA_WIDTH-1:0] pc_snap_q, pc_snap_d;
    logic [DATA_WIDTH-1:0] bp0_addr_q, bp0_addr_d;
    logic [DATA_WIDTH-1:0] bp1_addr_q, bp1_addr_d;
    logic                  bp0_en_q, bp0_en_d;
    logic                  bp1_en_q, bp1_en_d;
    logic [DATA_WIDTH-1:0] cycles_q, cycles_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  halt_req_q, halt_req_d;

    logic        bp0_hit, bp1_hit;
    logic        bp_set, to_set;
    logic        wr_en, ctrl_wr;
    logic        halt_cmd, resume_cmd, step_cmd;
    logic [31:0] idx;

    assign idx        = 32'(dbg_bus.core_dbg_addr);
    assign wr_en      = dbg_bus.core_dbg_req && dbg_bus.core_dbg_wr_rd;
    assign ctrl_wr    = wr_en && (idx == REG_CTRL);
    assign halt_cmd   = ctrl_wr && dbg_bus.core_dbg_wdata[CTRL_HALT_BIT];
    assign resume_cmd = ctrl_wr && dbg_bus.core_dbg_wdata[CTRL_RESUME_BIT];
    assign step_cmd   = ctrl_wr && dbg_bus.core_dbg_wdata[CTRL_STEP_BIT];

    core_dbg_bp_match #(.DATA_WIDTH(DATA_WIDTH)) u_bp0 (
        .en(bp0_en_q), .bp_addr(bp0_addr_q), .pc(core_pc), .hit(bp0_hit)
    );

    core_dbg_bp_match #(.DATA_WIDTH(DATA_WIDTH)) u_bp1 (
        .en(bp1_en_q), .bp_addr(bp1_addr_q), .pc(core_pc), .hit(bp1_hit)
    );

    // Run-control next state, cause and halt request
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        pc_snap_d = pc_snap_q;
        bp_set    = 1'b0;
        to_set    = 1'b0;
        case (state_q)
            ST_RUNNING: begin
                if (halt_cmd) begin
                    state_d = ST_HALTING;
                    cause_d = CAUSE_HALT;
                end else if (bp0_hit) begin
                    state_d = ST_HALTING;
                    cause_d = CAUSE_BP0;
                    bp_set  = 1'b1;
                end else if (bp1_hit) begin
                    state_d = ST_HALTING;
                    cause_d = CAUSE_BP1;
                    bp_set  = 1'b1;
                end
            end
            ST_HALTING: begin
                if (core_halted) begin
                    state_d   = ST_HALTED;
                    pc_snap_d = core_pc;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_RUNNING;
                    to_set  = 1'b1;
                end
            end
            ST_HALTED: begin
                if (halt_cmd) state_d = ST_HALTED;
                else if (step_cmd) state_d = ST_STEPPING;
                else if (resume_cmd) state_d = ST_RESUMING;
            end
            ST_RESUMING: begin
                if (!core_halted) begin
                    state_d = ST_RUNNING;
                    cause_d = CAUSE_NONE;
                end
            end
            ST_STEPPING: begin
                if (core_retire) begin
                    state_d = ST_HALTING;
                    cause_d = CAUSE_STEP;
                end
            end
            default: state_d = ST_RUNNING;
        endcase
        to_cnt_d   = (state_q == ST_HALTING && state_d == ST_HALTING) ? to_cnt_q + 1'b1 : '0;
        halt_req_d = (state_d == ST_HALTING) || (state_d == ST_HALTED);
    end

    // Register writes, sticky bits, cycle counter and read mux
    always_comb begin
        bp0_addr_d = bp0_addr_q;
        bp1_addr_d = bp1_addr_q;
        bp0_en_d   = bp0_en_q;
        bp1_en_d   = bp1_en_q;
        bp_hit_d   = bp_hit_q;
        to_err_d   = to_err_q;
        cycles_d   = (state_q == ST_RUNNING) ? cycles_q + 1'b1 : cycles_q;
        if (wr_en) begin
            case (idx)
                REG_STATUS_CLR: begin
                    if (dbg_bus.core_dbg_wdata[STAT_BPHIT_BIT]) bp_hit_d = 1'b0;
                    if (dbg_bus.core_dbg_wdata[STAT_TOERR_BIT]) to_err_d = 1'b0;
                end
                REG_BP0_ADDR: bp0_addr_d = dbg_bus.core_dbg_wdata;
                REG_BP0_CTRL: bp0_en_d   = dbg_bus.core_dbg_wdata[0];
                REG_BP1_ADDR: bp1_addr_d = dbg_bus.core_dbg_wdata;
                REG_BP1_CTRL: bp1_en_d   = dbg_bus.core_dbg_wdata[0];
                default: ;
            endcase
        end
        // A new event in the same cycle as its clear must not be lost
        if (bp_set) bp_hit_d = 1'b1;
        if (to_set) to_err_d = 1'b1;

        rvalid_d = dbg_bus.core_dbg_req && !dbg_bus.core_dbg_wr_rd;
        rdata_d  = rdata_q;
        if (rvalid_d) begin
            case (idx)
                REG_STATUS:   rdata_d = DATA_WIDTH'(pack_status(state_q, cause_q, bp_hit_q, to_err_q));
                REG_PC_SNAP:  rdata_d = pc_snap_q;
                REG_BP0_ADDR: rdata_d = bp0_addr_q;
                REG_BP0_CTRL: rdata_d = DATA_WIDTH'(bp0_en_q);
                REG_BP1_ADDR: rdata_d = bp1_addr_q;
                REG_BP1_CTRL: rdata_d = DATA_WIDTH'(bp1_en_q);
                REG_CYCLES:   rdata_d = cycles_q;
                REG_ID:       rdata_d = DBG_ID;
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUNNING;
            cause_q    <= CAUSE_NONE;
            to_cnt_q   <= '0;
            bp_hit_q   <= 1'b0;
            to_err_q   <= 1'b0;
            pc_snap_q  <= '0;
            bp0_addr_q <= '0;
            bp1_addr_q <= '0;
            bp0_en_q   <= 1'b0;
            bp1_en_q   <= 1'b0;
            cycles_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            halt_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            to_cnt_q   <= to_cnt_d;
            bp_hit_q   <= bp_hit_d;
            to_err_q   <= to_err_d;
            pc_snap_q  <= pc_snap_d;
            bp0_addr_q <= bp0_addr_d;
            bp1_addr_q <= bp1_addr_d;
            bp0_en_q   <= bp0_en_d;
            bp1_en_q   <= bp1_en_d;
            cycles_q   <= cycles_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            halt_req_q <= halt_req_d;
        end
    end

    assign dbg_bus.dbg_rdata  = rdata_q;
    assign dbg_bus.dbg_rvalid = rvalid_q;
    assign dbg_halt_req       = halt_req_q;

endmodule

// File: tb/tb_core_dbg_page.sv
// Directed bench for core_dbg_page: run control, breakpoints, timeout and reset.
module tb_core_dbg_page;
    import core_dbg_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] core_pc;
    logic        core_retire;
    logic        core_halted;
    logic        dbg_halt_req;
    int unsigned checks = 0;
    int unsigned errors = 0;

    core_dbg_page_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    core_dbg_page #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .HALT_TIMEOUT(64), .DBG_ID(32'hDC0D_0001)
    ) dut (
        .clk(clk), .rst(rst), .dbg_bus(bus), .core_pc(core_pc),
        .core_retire(core_retire), .core_halted(core_halted), .dbg_halt_req(dbg_halt_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input int unsigned idx, output logic [31:0] data, output logic valid);
        bus.core_dbg_req = 1'b1; bus.core_dbg_wr_rd = 1'b0; bus.core_dbg_addr = 5'(idx);
        tick();
        data = bus.dbg_rdata; valid = bus.dbg_rvalid;
        bus.core_dbg_req = 1'b0;
    endtask

    task automatic wr_reg(input int unsigned idx, input logic [31:0] data);
        bus.core_dbg_req = 1'b1; bus.core_dbg_wr_rd = 1'b1;
        bus.core_dbg_addr = 5'(idx); bus.core_dbg_wdata = data;
        tick();
        bus.core_dbg_req = 1'b0; bus.core_dbg_wr_rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.dbg_rdata); end
        checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", bus.dbg_rvalid); end
        checks++; if (dbg_halt_req !== 1'b0) begin errors++; $display("FAIL reset_halt_req got %b exp 0", dbg_halt_req); end
        rd_reg(REG_CYCLES, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reset_cycles0 got %h/%b exp 0/1", d, v); end
        rd_reg(REG_CYCLES, d, v);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_cycles1 got %h exp 1", d); end
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
        rd_reg(REG_ID, d, v);
        checks++; if (v !== 1'b1 || d !== 32'hDC0D_0001) begin errors++; $display("FAIL id_read got %h/%b exp dc0d0001/1", d, v); end
        tick();
        checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b exp 0", bus.dbg_rvalid); end
        rd_reg(31, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h/%b exp 0/1", d, v); end
    endtask

    task automatic test_halt();
        logic [31:0] d; logic v;
        core_pc = 32'h100; core_halted = 1'b0;
        wr_reg(REG_CTRL, 32'h1);
        checks++; if (dbg_halt_req !== 1'b1) begin errors++; $display("FAIL halt_req_rise got %b exp 1", dbg_halt_req); end
        checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid got %b exp 0", bus.dbg_rvalid); end
        tick(); tick();
        core_halted = 1'b1;
        tick();
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h12) begin errors++; $display("FAIL halt_status got %h exp 12", d); end
        rd_reg(REG_PC_SNAP, d, v);
        checks++; if (d !== 32'h100) begin errors++; $display("FAIL halt_pc_snap got %h exp 100", d); end
        checks++; if (dbg_halt_req !== 1'b1) begin errors++; $display("FAIL halted_halt_req got %b exp 1", dbg_halt_req); end
    endtask

    task automatic test_step_resume();
        logic [31:0] d, c1; logic v;
        wr_reg(REG_CTRL, 32'h4);
        checks++; if (dbg_halt_req !== 1'b0) begin errors++; $display("FAIL step_halt_req got %b exp 0", dbg_halt_req); end
        core_halted = 1'b0;
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h14) begin errors++; $display("FAIL step_status got %h exp 14", d); end
        core_retire = 1'b1; tick(); core_retire = 1'b0;
        checks++; if (dbg_halt_req !== 1'b1) begin errors++; $display("FAIL step_retire_halt_req got %b exp 1", dbg_halt_req); end
        core_pc = 32'h104; core_halted = 1'b1; tick();
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h42) begin errors++; $display("FAIL step_halted_status got %h exp 42", d); end
        rd_reg(REG_PC_SNAP, d, v);
        checks++; if (d !== 32'h104) begin errors++; $display("FAIL step_pc_snap got %h exp 104", d); end
        wr_reg(REG_CTRL, 32'h2);
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h43) begin errors++; $display("FAIL resuming_status got %h exp 43", d); end
        core_halted = 1'b0; tick();
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL resumed_status got %h exp 0", d); end
        rd_reg(REG_CYCLES, c1, v);
        rd_reg(REG_CYCLES, d, v);
        checks++; if (d !== c1 + 32'd1) begin errors++; $display("FAIL cycles_resume got %h exp %h", d, c1 + 32'd1); end
    endtask

    task automatic test_breakpoint();
        logic [31:0] d; logic v;
        core_pc = 32'h300;
        wr_reg(REG_BP0_ADDR, 32'h200); wr_reg(REG_BP0_CTRL, 32'h1);
        wr_reg(REG_BP1_ADDR, 32'h200); wr_reg(REG_BP1_CTRL, 32'h1);
        rd_reg(REG_BP0_ADDR, d, v);
        checks++; if (d !== 32'h200) begin errors++; $display("FAIL bp0_addr_rb got %h exp 200", d); end
        rd_reg(REG_BP1_CTRL, d, v);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL bp1_ctrl_rb got %h exp 1", d); end
        core_pc = 32'h200; tick();
        checks++; if (dbg_halt_req !== 1'b1) begin errors++; $display("FAIL bp0_halt_req got %b exp 1", dbg_halt_req); end
        core_pc = 32'h300; core_halted = 1'b1; tick();
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h122) begin errors++; $display("FAIL bp0_status got %h exp 122", d); end
        rd_reg(REG_PC_SNAP, d, v);
        checks++; if (d !== 32'h300) begin errors++; $display("FAIL bp0_pc_snap got %h exp 300", d); end
        wr_reg(REG_STATUS_CLR, 32'h100);
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h22) begin errors++; $display("FAIL bp_hit_clr got %h exp 22", d); end
        wr_reg(REG_BP0_CTRL, 32'h0);
        wr_reg(REG_CTRL, 32'h2); core_halted = 1'b0; tick();
        core_pc = 32'h200; tick();
        core_pc = 32'h300; core_halted = 1'b1; tick();
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h132) begin errors++; $display("FAIL bp1_status got %h exp 132", d); end
        wr_reg(REG_STATUS_CLR, 32'h100); wr_reg(REG_BP1_CTRL, 32'h0); wr_reg(REG_BP0_CTRL, 32'h1);
        wr_reg(REG_CTRL, 32'h2); core_halted = 1'b0; tick();
        core_pc = 32'h200;
        wr_reg(REG_CTRL, 32'h1);
        core_pc = 32'h300; core_halted = 1'b1; tick();
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h12) begin errors++; $display("FAIL halt_over_bp got %h exp 12", d); end
        wr_reg(REG_PC_SNAP, 32'hDEAD);
        rd_reg(REG_PC_SNAP, d, v);
        checks++; if (d !== 32'h300) begin errors++; $display("FAIL ro_write_ignored got %h exp 300", d); end
        wr_reg(REG_BP0_CTRL, 32'h0);
        wr_reg(REG_CTRL, 32'h2); core_halted = 1'b0; tick();
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic v;
        wr_reg(REG_CTRL, 32'h1);
        for (int i = 0; i < 10; i++) tick();
        wr_reg(REG_CTRL, 32'h2);
        for (int i = 0; i < 52; i++) tick();
        checks++; if (dbg_halt_req !== 1'b1) begin errors++; $display("FAIL timeout_last_cycle got %b exp 1", dbg_halt_req); end
        tick();
        checks++; if (dbg_halt_req !== 1'b0) begin errors++; $display("FAIL timeout_drop got %b exp 0", dbg_halt_req); end
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h210) begin errors++; $display("FAIL timeout_status got %h exp 210", d); end
        wr_reg(REG_STATUS_CLR, 32'h200);
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL timeout_clr got %h exp 10", d); end
    endtask

    task automatic test_halted_ctrl();
        logic [31:0] d; logic v;
        core_halted = 1'b1;
        wr_reg(REG_CTRL, 32'h1); tick();
        wr_reg(REG_CTRL, 32'h3);
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h12) begin errors++; $display("FAIL halt_wins got %h exp 12", d); end
        checks++; if (dbg_halt_req !== 1'b1) begin errors++; $display("FAIL halt_wins_req got %b exp 1", dbg_halt_req); end
        wr_reg(REG_CTRL, 32'h6);
        core_halted = 1'b0;
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h14) begin errors++; $display("FAIL step_wins got %h exp 14", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        rst = 1'b1; tick();
        checks++; if (dbg_halt_req !== 1'b0) begin errors++; $display("FAIL rst_mid_halt_req got %b exp 0", dbg_halt_req); end
        checks++; if (bus.dbg_rdata !== 32'h0 || bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_bus got %h/%b exp 0/0", bus.dbg_rdata, bus.dbg_rvalid); end
        rst = 1'b0;
        rd_reg(REG_CYCLES, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_cycles got %h exp 0", d); end
        rd_reg(REG_STATUS, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_status got %h exp 0", d); end
        rd_reg(REG_PC_SNAP, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_pc_snap got %h exp 0", d); end
        rd_reg(REG_BP0_ADDR, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_bp0_addr got %h exp 0", d); end
    endtask

    initial begin
        rst = 1'b1; core_pc = '0; core_retire = 1'b0; core_halted = 1'b0;
        bus.core_dbg_req = 1'b0; bus.core_dbg_wr_rd = 1'b0;
        bus.core_dbg_addr = '0; bus.core_dbg_wdata = '0;
        test_reset();
        test_halt();
        test_step_resume();
        test_breakpoint();
        test_timeout();
        test_halted_ctrl();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
